// File: rtl/cnn_seq_pkg.sv
// Shared register map, STATUS bit positions and FSM encoding for the CNN layer sequencer.
package cnn_seq_pkg;

    localparam logic [5:0] OFF_CTRL    = 6'd0;
    localparam logic [5:0] OFF_STATUS  = 6'd1;
    localparam logic [5:0] OFF_NUM     = 6'd2;
    localparam logic [5:0] OFF_TIMEOUT = 6'd3;
    localparam logic [5:0] OFF_DESC    = 6'd16;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_IRQEN = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;
    localparam int STAT_TIMEOUT = 3;
    localparam int STAT_IDX_LSB = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [1:0] HRESP_OKAY = 2'b00;

endpackage

// File: rtl/cnn_layer_seq.sv
// AHB-Lite programmed sequencer that walks a flop-based descriptor table and
// hands one layer at a time to the conv engine, with abort and watchdog.
module cnn_layer_seq
    import cnn_seq_pkg::*;
#(
    parameter int  W_ADDR      = 32,
    parameter int  W_DATA      = 32,
    parameter int  N_LAYER_MAX = 8,
    parameter int  W_TIMEOUT   = 16,
    localparam int W_LAYER     = (N_LAYER_MAX > 1) ? $clog2(N_LAYER_MAX) : 1
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               sl_HSEL,
    input  logic               sl_HREADY,
    input  logic               sl_HWRITE,
    input  logic [1:0]         sl_HTRANS,
    input  logic [W_ADDR-1:0]  sl_HADDR,
    input  logic [W_DATA-1:0]  sl_HWDATA,
    output logic               out_sl_HREADY,
    output logic [1:0]         out_sl_HRESP,
    output logic [W_DATA-1:0]  out_sl_HRDATA,
    output logic               o_layer_start,
    output logic [31:0]        o_layer_cfg,
    output logic [31:0]        o_layer_base,
    output logic [W_LAYER-1:0] o_layer_idx,
    input  logic               i_layer_done,
    output logic               o_irq
);

    localparam logic [4:0] NUM_MAX = 5'(N_LAYER_MAX);

    logic                 r_valid;
    logic                 r_wr;
    logic [5:0]           r_off;
    logic [1:0]           r_state;
    logic [W_LAYER-1:0]   r_idx;
    logic [4:0]           r_num;
    logic [W_TIMEOUT-1:0] r_timeout;
    logic [W_TIMEOUT-1:0] r_wd;
    logic                 r_irq_en;
    logic                 r_done;
    logic                 r_aborted;
    logic                 r_tmo;
    logic [31:0]          r_cfg  [N_LAYER_MAX];
    logic [31:0]          r_base [N_LAYER_MAX];

    logic [31:0] w_wdata;
    logic        w_addr_ok;
    logic        w_wr_en;
    logic        w_busy;
    logic        w_start;
    logic        w_abort;
    logic        w_stat_wr;
    logic        w_desc_wr;
    logic [5:0]  w_desc_off;
    logic        w_last;
    logic        w_wd_hit;
    logic [1:0]  w_nxt_state;
    logic        w_idx_clr;
    logic        w_idx_inc;
    logic        w_set_done;
    logic        w_set_abort;
    logic        w_set_tmo;
    logic [31:0] w_rd;
    logic [31:0] w_cur_cfg;
    logic [31:0] w_cur_base;
    logic        w_unused;

    assign w_wdata    = 32'(sl_HWDATA);
    assign w_addr_ok  = sl_HSEL && sl_HREADY && sl_HTRANS[1];
    assign w_wr_en    = r_valid && r_wr;
    assign w_busy     = (r_state != ST_IDLE);
    assign w_start    = w_wr_en && (r_off == OFF_CTRL) && w_wdata[CTRL_START];
    assign w_abort    = w_wr_en && (r_off == OFF_CTRL) && w_wdata[CTRL_ABORT];
    assign w_stat_wr  = w_wr_en && (r_off == OFF_STATUS);
    assign w_desc_off = r_off - OFF_DESC;
    assign w_desc_wr  = w_wr_en && !w_busy && (r_off >= OFF_DESC);
    assign w_last     = (5'(r_idx) == r_num - 5'd1);
    assign w_wd_hit   = (r_timeout != '0) && ((r_wd + 1'b1) == r_timeout);

    assign out_sl_HREADY = 1'b1;
    assign out_sl_HRESP  = HRESP_OKAY;
    assign out_sl_HRDATA = W_DATA'(w_rd);
    assign o_layer_start = (r_state == ST_ISSUE);
    assign o_layer_cfg   = w_cur_cfg;
    assign o_layer_base  = w_cur_base;
    assign o_layer_idx   = r_idx;
    assign o_irq         = r_irq_en & (r_done | r_aborted | r_tmo);

    assign w_unused = &{1'b0, sl_HADDR[1:0], sl_HADDR[W_ADDR-1:8], sl_HTRANS[0]};

    // Address phase capture; the write itself lands in the following cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_valid <= 1'b0;
            r_wr    <= 1'b0;
            r_off   <= '0;
        end else begin
            r_valid <= w_addr_ok;
            if (w_addr_ok) begin
                r_wr  <= sl_HWRITE;
                r_off <= sl_HADDR[7:2];
            end
        end
    end

    // Abort outranks a coincident done, and done outranks the watchdog.
    always_comb begin
        w_nxt_state = r_state;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_set_done  = 1'b0;
        w_set_abort = 1'b0;
        w_set_tmo   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (r_num != 5'd0) begin
                        w_nxt_state = ST_ISSUE;
                        w_idx_clr   = 1'b1;
                    end else begin
                        w_set_done = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_abort) begin
                    w_nxt_state = ST_IDLE;
                    w_set_abort = 1'b1;
                end else begin
                    w_nxt_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_nxt_state = ST_IDLE;
                    w_set_abort = 1'b1;
                end else if (i_layer_done) begin
                    if (w_last) begin
                        w_nxt_state = ST_IDLE;
                        w_set_done  = 1'b1;
                    end else begin
                        w_nxt_state = ST_ISSUE;
                        w_idx_inc   = 1'b1;
                    end
                end else if (w_wd_hit) begin
                    w_nxt_state = ST_IDLE;
                    w_set_tmo   = 1'b1;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_num     <= '0;
            r_timeout <= '0;
            r_wd      <= '0;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == ST_ISSUE) begin
                r_wd <= '0;
            end else if (r_state == ST_RUN) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_wr_en && (r_off == OFF_CTRL)) begin
                r_irq_en <= w_wdata[CTRL_IRQEN];
            end
            if (w_wr_en && !w_busy && (r_off == OFF_NUM)) begin
                r_num <= (w_wdata[4:0] > NUM_MAX) ? NUM_MAX : w_wdata[4:0];
            end
            if (w_wr_en && (r_off == OFF_TIMEOUT)) begin
                r_timeout <= w_wdata[W_TIMEOUT-1:0];
            end
            // A set in the same cycle as its W1C clear wins.
            r_done    <= w_set_done  | (r_done    & ~(w_stat_wr & w_wdata[STAT_DONE]));
            r_aborted <= w_set_abort | (r_aborted & ~(w_stat_wr & w_wdata[STAT_ABORTED]));
            r_tmo     <= w_set_tmo   | (r_tmo     & ~(w_stat_wr & w_wdata[STAT_TIMEOUT]));
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < N_LAYER_MAX; i++) begin
                r_cfg[i]  <= '0;
                r_base[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_LAYER_MAX; i++) begin
                if (w_desc_wr && (w_desc_off[5:1] == 5'(i))) begin
                    if (w_desc_off[0]) begin
                        r_base[i] <= w_wdata;
                    end else begin
                        r_cfg[i] <= w_wdata;
                    end
                end
            end
        end
    end

    always_comb begin
        w_cur_cfg  = '0;
        w_cur_base = '0;
        for (int i = 0; i < N_LAYER_MAX; i++) begin
            if (w_busy && (r_idx == W_LAYER'(i))) begin
                w_cur_cfg  = r_cfg[i];
                w_cur_base = r_base[i];
            end
        end
    end

    // Read data is only driven during a read data phase, so it idles at 0.
    always_comb begin
        w_rd = '0;
        if (r_valid && !r_wr) begin
            case (r_off)
                OFF_CTRL:    w_rd[CTRL_IRQEN] = r_irq_en;
                OFF_STATUS: begin
                    w_rd[STAT_BUSY]               = w_busy;
                    w_rd[STAT_DONE]               = r_done;
                    w_rd[STAT_ABORTED]            = r_aborted;
                    w_rd[STAT_TIMEOUT]            = r_tmo;
                    w_rd[STAT_IDX_LSB +: W_LAYER] = r_idx;
                end
                OFF_NUM:     w_rd[4:0] = r_num;
                OFF_TIMEOUT: w_rd[W_TIMEOUT-1:0] = r_timeout;
                default: begin
                    for (int i = 0; i < N_LAYER_MAX; i++) begin
                        if ((r_off >= OFF_DESC) && (w_desc_off[5:1] == 5'(i))) begin
                            w_rd = w_desc_off[0] ? r_base[i] : r_cfg[i];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Testbench for cnn_layer_seq: register table, directed sequences and randomized runs
// against a behavioural model of the layer walk.
module tb_cnn_layer_seq;

    localparam int W_ADDR      = 32;
    localparam int W_DATA      = 32;
    localparam int N_LAYER_MAX = 8;
    localparam int W_TIMEOUT   = 16;
    localparam int W_LAYER     = 3;

    localparam logic [5:0] A_CTRL   = 6'd0;
    localparam logic [5:0] A_STATUS = 6'd1;
    localparam logic [5:0] A_NUM    = 6'd2;
    localparam logic [5:0] A_TMO    = 6'd3;
    localparam logic [5:0] A_DESC   = 6'd16;

    logic               HCLK = 1'b0;
    logic               HRESETn;
    logic               sel, ready, write;
    logic [1:0]         trans;
    logic [W_ADDR-1:0]  addr;
    logic [W_DATA-1:0]  wdata;
    logic               hready_o;
    logic [1:0]         hresp;
    logic [W_DATA-1:0]  hrdata;
    logic               o_layer_start;
    logic [31:0]        o_layer_cfg;
    logic [31:0]        o_layer_base;
    logic [W_LAYER-1:0] o_layer_idx;
    logic               i_layer_done;
    logic               o_irq;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_cfg  [N_LAYER_MAX];
    logic [31:0] m_base [N_LAYER_MAX];

    typedef struct {
        logic [5:0]  off;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[15];

    cnn_layer_seq #(
        .W_ADDR(W_ADDR), .W_DATA(W_DATA), .N_LAYER_MAX(N_LAYER_MAX), .W_TIMEOUT(W_TIMEOUT)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .sl_HSEL(sel), .sl_HREADY(ready), .sl_HWRITE(write), .sl_HTRANS(trans),
        .sl_HADDR(addr), .sl_HWDATA(wdata),
        .out_sl_HREADY(hready_o), .out_sl_HRESP(hresp), .out_sl_HRDATA(hrdata),
        .o_layer_start(o_layer_start), .o_layer_cfg(o_layer_cfg), .o_layer_base(o_layer_base),
        .o_layer_idx(o_layer_idx), .i_layer_done(i_layer_done), .o_irq(o_irq)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_addr(input logic [5:0] off, input logic wr);
        sel   = 1'b1;
        trans = 2'b10;
        addr  = {24'd0, off, 2'b00};
        write = wr;
    endtask

    task automatic bus_idle();
        sel   = 1'b0;
        trans = 2'b00;
        write = 1'b0;
    endtask

    task automatic ahb_write(input logic [5:0] off, input logic [31:0] d);
        bus_addr(off, 1'b1);
        tick();
        bus_idle();
        wdata = d;
        tick();
    endtask

    task automatic ahb_read(input logic [5:0] off, output logic [31:0] d);
        bus_addr(off, 1'b0);
        tick();
        bus_idle();
        d = hrdata;
        tick();
    endtask

    task automatic check_rd(input string name, input logic [5:0] off, input logic [31:0] exp);
        logic [31:0] d;
        ahb_read(off, d);
        check(name, d, exp);
    endtask

    task automatic program_desc(input int i, input logic [31:0] c, input logic [31:0] b);
        ahb_write(6'(A_DESC + 2 * i), c);
        ahb_write(6'(A_DESC + 2 * i + 1), b);
        m_cfg[i]  = c;
        m_base[i] = b;
    endtask

    function automatic logic [31:0] exp_status(input bit dn, input bit ab, input bit tm, input int idx);
        return (32'(idx) << 8) | (32'(tm) << 3) | (32'(ab) << 2) | (32'(dn) << 1);
    endfunction

    // Entered in the ISSUE cycle of layer 0; leaves right after the last layer's done.
    task automatic run_seq(input int n, input int lat_max);
        for (int i = 0; i < n; i++) begin
            int d;
            check($sformatf("start_l%0d", i), 32'(o_layer_start), 32'd1);
            check($sformatf("idx_l%0d", i), 32'(o_layer_idx), 32'(i));
            check($sformatf("cfg_l%0d", i), o_layer_cfg, m_cfg[i]);
            check($sformatf("base_l%0d", i), o_layer_base, m_base[i]);
            tick();
            check($sformatf("start_width_l%0d", i), 32'(o_layer_start), 32'd0);
            d = $urandom_range(0, lat_max);
            for (int k = 0; k < d; k++) begin
                tick();
                check("no_start_in_run", 32'(o_layer_start), 32'd0);
            end
            check($sformatf("cfg_hold_l%0d", i), o_layer_cfg, m_cfg[i]);
            i_layer_done = 1'b1;
            tick();
            i_layer_done = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd;
        HRESETn      = 1'b0;
        sel          = 1'b0;
        ready        = 1'b1;
        write        = 1'b0;
        trans        = 2'b00;
        addr         = '0;
        wdata        = '0;
        i_layer_done = 1'b0;
        for (int i = 0; i < N_LAYER_MAX; i++) begin
            m_cfg[i]  = '0;
            m_base[i] = '0;
        end

        #2;
        check("rst_start", 32'(o_layer_start), 32'd0);
        check("rst_irq", 32'(o_irq), 32'd0);
        check("rst_cfg", o_layer_cfg, 32'd0);
        check("rst_base", o_layer_base, 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("hready_const", 32'(hready_o), 32'd1);
        check("hresp_const", 32'(hresp), 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        tick();

        check_rd("rst_ctrl", A_CTRL, 32'd0);
        check_rd("rst_status", A_STATUS, 32'd0);
        check_rd("rst_num", A_NUM, 32'd0);
        check_rd("rst_tmo", A_TMO, 32'd0);
        check_rd("rst_cfg0", A_DESC, 32'd0);

        tbl[0]  = '{A_NUM,   32'd3,          32'd3};
        tbl[1]  = '{A_NUM,   32'd20,         32'd8};
        tbl[2]  = '{A_NUM,   32'd8,          32'd8};
        tbl[3]  = '{A_NUM,   32'd9,          32'd8};
        tbl[4]  = '{A_NUM,   32'h25,         32'd5};
        tbl[5]  = '{A_TMO,   32'h1234,       32'h1234};
        tbl[6]  = '{A_TMO,   32'hABCDE,      32'hBCDE};
        tbl[7]  = '{A_TMO,   32'd0,          32'd0};
        tbl[8]  = '{6'd16,   32'hDEADBEEF,   32'hDEADBEEF};
        tbl[9]  = '{6'd31,   32'h12345678,   32'h12345678};
        tbl[10] = '{6'd32,   32'hFFFFFFFF,   32'd0};
        tbl[11] = '{6'd5,    32'hFFFFFFFF,   32'd0};
        tbl[12] = '{A_CTRL,  32'd4,          32'd4};
        tbl[13] = '{A_CTRL,  32'hFFFFFFF8,   32'd0};
        tbl[14] = '{A_STATUS, 32'hFFFFFFFF,  32'd0};
        for (int i = 0; i < 15; i++) begin
            ahb_write(tbl[i].off, tbl[i].wdata);
            check_rd($sformatf("tbl%0d", i), tbl[i].off, tbl[i].exp);
        end

        // Three-layer walk
        for (int i = 0; i < 3; i++) program_desc(i, 32'hC0DE0000 + 32'(i), 32'hBA5E0000 + 32'(i * 16));
        ahb_write(A_NUM, 32'd3);
        ahb_write(A_CTRL, 32'd1);
        run_seq(3, 3);
        check("after3_start", 32'(o_layer_start), 32'd0);
        check("after3_cfg_idle", o_layer_cfg, 32'd0);
        check_rd("after3_status", A_STATUS, exp_status(1, 0, 0, 2));
        i_layer_done = 1'b1;
        tick();
        i_layer_done = 1'b0;
        check("done_in_idle", 32'(o_layer_start), 32'd0);
        check_rd("done_in_idle_status", A_STATUS, exp_status(1, 0, 0, 2));

        // Interrupt on a one-layer run, cleared by W1C
        ahb_write(A_STATUS, 32'hE);
        ahb_write(A_NUM, 32'd1);
        ahb_write(A_CTRL, 32'd5);
        check("irq_while_run", 32'(o_irq), 32'd0);
        run_seq(1, 2);
        check("irq_after_done", 32'(o_irq), 32'd1);
        ahb_write(A_STATUS, 32'd2);
        check("irq_after_w1c", 32'(o_irq), 32'd0);

        // Zero layers: immediate done, no pulse
        ahb_write(A_NUM, 32'd0);
        ahb_write(A_CTRL, 32'd1);
        check("num0_start", 32'(o_layer_start), 32'd0);
        tick();
        check("num0_start2", 32'(o_layer_start), 32'd0);
        check_rd("num0_status", A_STATUS, exp_status(1, 0, 0, 0));
        ahb_write(A_STATUS, 32'hE);

        // Watchdog
        program_desc(0, 32'h00000011, 32'h00000022);
        ahb_write(A_NUM, 32'd1);
        ahb_write(A_TMO, 32'd10);
        ahb_write(A_CTRL, 32'd1);
        check("tmo_start", 32'(o_layer_start), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("tmo_busy_c%0d", k), o_layer_cfg, 32'h11);
        end
        tick();
        check("tmo_idle_cfg", o_layer_cfg, 32'd0);
        check("tmo_no_restart", 32'(o_layer_start), 32'd0);
        check_rd("tmo_status", A_STATUS, exp_status(0, 0, 1, 0));
        ahb_write(A_TMO, 32'd0);
        ahb_write(A_STATUS, 32'hE);

        // W1C of done colliding with a fresh done
        ahb_write(A_CTRL, 32'd1);
        run_seq(1, 1);
        ahb_write(A_CTRL, 32'd1);
        check("coll_start", 32'(o_layer_start), 32'd1);
        tick();
        bus_addr(A_STATUS, 1'b1);
        tick();
        bus_idle();
        wdata        = 32'd2;
        i_layer_done = 1'b1;
        tick();
        i_layer_done = 1'b0;
        check_rd("coll_status", A_STATUS, exp_status(1, 0, 0, 0));
        ahb_write(A_STATUS, 32'hE);

        // Abort colliding with done on layer 1 of 4
        for (int i = 0; i < 4; i++) program_desc(i, 32'hA0000000 | 32'(i), 32'hB0000000 | 32'(i));
        ahb_write(A_NUM, 32'd4);
        ahb_write(A_CTRL, 32'd1);
        run_seq(1, 2);
        check("abort_l1_start", 32'(o_layer_start), 32'd1);
        check("abort_l1_idx", 32'(o_layer_idx), 32'd1);
        tick();
        bus_addr(A_CTRL, 1'b1);
        tick();
        bus_idle();
        wdata        = 32'd2;
        i_layer_done = 1'b1;
        tick();
        i_layer_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("abort_no_start", 32'(o_layer_start), 32'd0);
            tick();
        end
        check_rd("abort_status", A_STATUS, exp_status(0, 1, 0, 1));
        ahb_write(A_STATUS, 32'hE);

        // Writes while busy are dropped
        program_desc(0, 32'hCAFE0001, 32'hCAFE0002);
        ahb_write(A_NUM, 32'd2);
        ahb_write(A_CTRL, 32'd1);
        tick();
        ahb_write(A_DESC, 32'hBAD0BAD0);
        ahb_write(A_NUM, 32'd5);
        ahb_write(A_CTRL, 32'd1);
        check("busy_idx", 32'(o_layer_idx), 32'd0);
        check("busy_no_restart", 32'(o_layer_start), 32'd0);
        check_rd("busy_cfg0", A_DESC, m_cfg[0]);
        check_rd("busy_num", A_NUM, 32'd2);
        check_rd("busy_status", A_STATUS, 32'h1);
        ahb_write(A_CTRL, 32'd2);
        check_rd("busy_abort_status", A_STATUS, exp_status(0, 1, 0, 0));
        ahb_write(A_STATUS, 32'hE);

        // Randomized runs against the model
        for (int it = 0; it < 6; it++) begin
            int num_req;
            int exp_num;
            num_req = $urandom_range(1, 31);
            exp_num = (num_req > N_LAYER_MAX) ? N_LAYER_MAX : num_req;
            ahb_write(A_NUM, 32'(num_req));
            check_rd($sformatf("rnd%0d_num", it), A_NUM, 32'(exp_num));
            for (int i = 0; i < exp_num; i++) program_desc(i, $urandom(), $urandom());
            ahb_write(A_CTRL, 32'd1);
            run_seq(exp_num, 4);
            check_rd($sformatf("rnd%0d_status", it), A_STATUS, exp_status(1, 0, 0, exp_num - 1));
            ahb_write(A_STATUS, 32'hE);
        end

        // Reset in the middle of a run, with the interrupt pending
        program_desc(0, 32'h55AA55AA, 32'hAA55AA55);
        ahb_write(A_CTRL, 32'd2);
        ahb_write(A_NUM, 32'd3);
        ahb_write(A_CTRL, 32'd5);
        check("pre_rst_irq", 32'(o_irq), 32'd0);
        tick();
        check("pre_rst_cfg", o_layer_cfg, 32'h55AA55AA);
        #2;
        HRESETn = 1'b0;
        #1;
        check("midrst_start", 32'(o_layer_start), 32'd0);
        check("midrst_irq", 32'(o_irq), 32'd0);
        check("midrst_cfg", o_layer_cfg, 32'd0);
        check("midrst_base", o_layer_base, 32'd0);
        check("midrst_idx", 32'(o_layer_idx), 32'd0);
        check("midrst_hrdata", hrdata, 32'd0);
        tick();
        tick();
        HRESETn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("postrst_no_start", 32'(o_layer_start), 32'd0);
        end
        check_rd("postrst_status", A_STATUS, 32'd0);
        check_rd("postrst_num", A_NUM, 32'd0);
        check_rd("postrst_cfg0", A_DESC, 32'd0);
        check_rd("postrst_ctrl", A_CTRL, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
